// File: rtl/axi4_r_return_arbiter.sv
// axi4_r_return_arbiter
// Read-return path of one crossbar master port. Slave R beats whose RID index
// bits select this master are arbitrated round-robin, locked per burst until
// RLAST, stripped of the index bits and queued in a small FIFO toward the master.
module axi4_r_return_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int MASTER_IDX = 0,
    parameter int SLAVE_NUM  = 8,
    parameter int R_ID_LEN   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BUF_DEPTH  = 2,
    localparam int EXTRA_ID_LEN = $clog2(MASTER_NUM),
    localparam int IDW          = EXTRA_ID_LEN + R_ID_LEN
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic [SLAVE_NUM*IDW-1:0]        S_RID,
    input  logic [SLAVE_NUM*DATA_WIDTH-1:0] S_RDATA,
    input  logic [SLAVE_NUM*2-1:0]          S_RRESP,
    input  logic [SLAVE_NUM-1:0]            S_RLAST,
    input  logic [SLAVE_NUM-1:0]            S_RVALID,
    output logic [SLAVE_NUM-1:0]            S_RREADY,
    output logic [R_ID_LEN-1:0]             M_RID,
    output logic [DATA_WIDTH-1:0]           M_RDATA,
    output logic [1:0]                      M_RRESP,
    output logic                            M_RLAST,
    output logic                            M_RVALID,
    input  logic                            M_RREADY
);

    localparam int GW = $clog2(SLAVE_NUM);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int EW = R_ID_LEN + DATA_WIDTH + 3;
    localparam logic [EXTRA_ID_LEN-1:0] MIDX = EXTRA_ID_LEN'(MASTER_IDX);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [EW-1:0]   mem_q [BUF_DEPTH];
    logic [EW-1:0]   mem_d [BUF_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [SLAVE_NUM-1:0] req;
    logic [GW-1:0]        grant;
    logic                 grant_ok;
    int                   scan_idx;
    logic                 fifo_full;
    logic                 beat_accept;
    logic                 beat_last;
    logic                 pop;
    logic [EW-1:0]        entry;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(BUF_DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    // A slot requests only when its RID index bits route the beat to this master
    always_comb begin
        req = '0;
        for (int s = 0; s < SLAVE_NUM; s++) begin
            req[s] = S_RVALID[s] && (S_RID[s*IDW + R_ID_LEN +: EXTRA_ID_LEN] == MIDX);
        end
    end

    // Pick the grant: held slave during a burst, otherwise first requester after last_grant
    always_comb begin
        grant    = grant_q;
        grant_ok = 1'b0;
        scan_idx = 0;
        if (state_q == BURST) begin
            grant_ok = 1'b1;
        end else begin
            for (int i = 0; i < SLAVE_NUM; i++) begin
                scan_idx = int'(last_grant_q) + 1 + i;
                if (scan_idx >= SLAVE_NUM) scan_idx = scan_idx - SLAVE_NUM;
                if (!grant_ok && req[scan_idx]) begin
                    grant    = scan_idx[GW-1:0];
                    grant_ok = 1'b1;
                end
            end
        end
    end

    assign fifo_full   = (count_q == CW'(BUF_DEPTH));
    assign beat_accept = ARESETn && grant_ok && req[grant] && !fifo_full;
    assign beat_last   = S_RLAST[grant];
    assign entry       = {S_RID[int'(grant)*IDW +: R_ID_LEN],
                          S_RDATA[int'(grant)*DATA_WIDTH +: DATA_WIDTH],
                          S_RRESP[int'(grant)*2 +: 2],
                          beat_last};

    // Only the granted slot sees ready, and never while the FIFO is full or in reset
    always_comb begin
        S_RREADY = '0;
        if (beat_accept) S_RREADY[grant] = 1'b1;
    end

    // Burst lock: enter BURST on a non-last beat, leave and rotate priority on RLAST
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (beat_accept) begin
            if (beat_last) begin
                state_d      = IDLE;
                last_grant_d = grant;
            end else begin
                state_d = BURST;
                grant_d = grant;
            end
        end
    end

    assign M_RVALID = (count_q != '0);
    assign pop      = M_RVALID && M_RREADY;
    assign {M_RID, M_RDATA, M_RRESP, M_RLAST} = mem_q[rd_ptr_q];

    // FIFO bookkeeping: write accepted beats, advance head on master handshake
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (beat_accept) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({beat_accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Arbitration state registers; reset gives slave 0 first priority
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(SLAVE_NUM - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // FIFO storage registers; reset discards contents and zeroes the head
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_axi4_r_return_arbiter.sv
// tb_axi4_r_return_arbiter
// Slave-side beat queues feed the DUT, expected master beats sit in a scoreboard
// queue in the order the arbitration rules dictate, and a table of request
// patterns checks the combinational grant/filter logic.
module tb_axi4_r_return_arbiter;

    localparam int SN  = 8;
    localparam int IDW = 6;
    localparam int DW  = 64;

    logic              ACLK = 1'b0;
    logic              ARESETn;
    logic [SN*IDW-1:0] S_RID;
    logic [SN*DW-1:0]  S_RDATA;
    logic [SN*2-1:0]   S_RRESP;
    logic [SN-1:0]     S_RLAST;
    logic [SN-1:0]     S_RVALID;
    logic [SN-1:0]     S_RREADY;
    logic [3:0]        M_RID;
    logic [63:0]       M_RDATA;
    logic [1:0]        M_RRESP;
    logic              M_RLAST;
    logic              M_RVALID;
    logic              M_RREADY;

    axi4_r_return_arbiter dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .S_RID    (S_RID),
        .S_RDATA  (S_RDATA),
        .S_RRESP  (S_RRESP),
        .S_RLAST  (S_RLAST),
        .S_RVALID (S_RVALID),
        .S_RREADY (S_RREADY),
        .M_RID    (M_RID),
        .M_RDATA  (M_RDATA),
        .M_RRESP  (M_RRESP),
        .M_RLAST  (M_RLAST),
        .M_RVALID (M_RVALID),
        .M_RREADY (M_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [5:0]  rid;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        string      name;
        logic [7:0] valid;
        logic [7:0] foreign;
        logic [7:0] expReady;
    } vec_t;

    beat_t      slaveQ [SN][$];
    beat_t      sb [$];
    vec_t       vecs [10];
    int         checks = 0;
    int         errors = 0;
    int         acceptCount = 0;
    int         cycleCnt = 0;
    int         hsCount = 0;
    int         firstHs = 0;
    int         lastHs = 0;
    logic [7:0] sReadySample;
    logic       mValidSample;
    logic [SN-1:0] hs;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic mkBurst(input int slot, input int n, input logic [1:0] idx, input logic [3:0] idLow,
                           input logic [63:0] base, input bit toSb);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.rid  = {idx, idLow};
            b.data = base + 64'(i);
            b.resp = 2'(i);
            b.last = (i == n - 1);
            slaveQ[slot].push_back(b);
            if (toSb) sb.push_back(b);
        end
    endtask

    task automatic driveSlaves();
        beat_t b;
        for (int s = 0; s < SN; s++) begin
            if (hs[s] && slaveQ[s].size() > 0) slaveQ[s].delete(0);
            if (slaveQ[s].size() > 0) begin
                b = slaveQ[s][0];
                S_RID[s*IDW +: IDW] = b.rid;
                S_RDATA[s*DW +: DW] = b.data;
                S_RRESP[s*2 +: 2]   = b.resp;
                S_RLAST[s]          = b.last;
                S_RVALID[s]         = 1'b1;
            end else begin
                S_RVALID[s] = 1'b0;
            end
        end
    endtask

    task automatic monitorOutput();
        beat_t e;
        if (M_RVALID && !M_RREADY && sb.size() > 0) begin
            e = sb[0];
            checkOutput("hold_rid", 64'(M_RID), 64'(e.rid[3:0]));
            checkOutput("hold_rdata", M_RDATA, e.data);
            checkOutput("hold_rlast", 64'(M_RLAST), 64'(e.last));
        end
        if (M_RVALID && M_RREADY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got rid %0h data %0h expected no beat", M_RID, M_RDATA);
            end else begin
                e = sb.pop_front();
                checkOutput("m_rid", 64'(M_RID), 64'(e.rid[3:0]));
                checkOutput("m_rdata", M_RDATA, e.data);
                checkOutput("m_rresp", 64'(M_RRESP), 64'(e.resp));
                checkOutput("m_rlast", 64'(M_RLAST), 64'(e.last));
            end
            if (hsCount == 0) firstHs = cycleCnt;
            lastHs = cycleCnt;
            hsCount++;
        end
    endtask

    // One clock: sample at the falling edge, then update slave drivers just after the rising edge
    task automatic tick();
        @(negedge ACLK);
        cycleCnt++;
        monitorOutput();
        sReadySample = S_RREADY;
        mValidSample = M_RVALID;
        hs           = S_RVALID & S_RREADY;
        acceptCount += $countones(hs);
        @(posedge ACLK);
        #1;
        driveSlaves();
    endtask

    function automatic bit slavesBusy();
        for (int s = 0; s < SN; s++) if (slaveQ[s].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while ((sb.size() > 0 || slavesBusy()) && n < maxCycles) begin
            tick();
            n++;
        end
        if (sb.size() > 0 || slavesBusy()) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
        end
    endtask

    task automatic resetDut();
        ARESETn  = 1'b0;
        S_RVALID = '0;
        hs       = '0;
        for (int s = 0; s < SN; s++) slaveQ[s].delete();
        sb.delete();
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int s = 0; s < SN; s++) begin
            S_RID[s*IDW +: IDW] = {v.foreign[s] ? 2'(s % 3 + 1) : 2'b00, 4'(s)};
        end
        S_RVALID = v.valid;
    endtask

    // Safety net so a stuck DUT cannot hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        vecs[0] = '{"vec_none",        8'h00, 8'h00, 8'h00};
        vecs[1] = '{"vec_single2",     8'h04, 8'h00, 8'h04};
        vecs[2] = '{"vec_filter4",     8'h10, 8'h10, 8'h00};
        vecs[3] = '{"vec_all",         8'hFF, 8'h00, 8'h01};
        vecs[4] = '{"vec_all_skip0",   8'hFF, 8'h01, 8'h02};
        vecs[5] = '{"vec_only7",       8'h80, 8'h00, 8'h80};
        vecs[6] = '{"vec_filter_pick", 8'h90, 8'h10, 8'h80};
        vecs[7] = '{"vec_6_7",         8'hC0, 8'h00, 8'h40};
        vecs[8] = '{"vec_all_foreign", 8'hFF, 8'hFF, 8'h00};
        vecs[9] = '{"vec_1_3",         8'h0A, 8'h00, 8'h02};

        ARESETn  = 1'b0;
        S_RID    = '0;
        S_RDATA  = '0;
        S_RRESP  = '0;
        S_RLAST  = '0;
        S_RVALID = '0;
        M_RREADY = 1'b1;
        hs       = '0;

        // T1: reset holds everything quiet even with a matching request present
        mkBurst(2, 1, 2'b00, 4'h1, 64'h1111, 1'b1);
        driveSlaves();
        repeat (2) @(negedge ACLK);
        checkOutput("rst_s_rready", 64'(S_RREADY), 64'd0);
        checkOutput("rst_m_rvalid", 64'(M_RVALID), 64'd0);
        checkOutput("rst_m_rid",    64'(M_RID), 64'd0);
        checkOutput("rst_m_rdata",  M_RDATA, 64'd0);
        checkOutput("rst_m_rlast",  64'(M_RLAST), 64'd0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        tick();
        checkOutput("t1_s_rready", 64'(sReadySample), 64'h04);
        waitDrain(20);

        // T2: single beat, one cycle of latency to the master side
        mkBurst(3, 1, 2'b00, 4'h5, 64'hDEAD, 1'b1);
        tick();
        tick();
        checkOutput("t2_s_rready", 64'(sReadySample), 64'h08);
        checkOutput("t2_m_rvalid_early", 64'(mValidSample), 64'd0);
        tick();
        checkOutput("t2_m_rvalid", 64'(mValidSample), 64'd1);
        waitDrain(20);

        // T3: burst lock keeps slave 2 out until slave 1 sends RLAST
        mkBurst(1, 4, 2'b00, 4'hA, 64'h1000, 1'b1);
        tick();
        mkBurst(2, 2, 2'b00, 4'hB, 64'h2000, 1'b1);
        waitDrain(50);

        // T4: round robin 0,1,7 twice at one beat per cycle
        resetDut();
        hsCount = 0;
        for (int r = 0; r < 2; r++) begin
            mkBurst(0, 1, 2'b00, 4'h0, 64'h4000 + 64'(r), 1'b1);
            mkBurst(1, 1, 2'b00, 4'h1, 64'h4100 + 64'(r), 1'b1);
            mkBurst(7, 1, 2'b00, 4'h7, 64'h4700 + 64'(r), 1'b1);
        end
        waitDrain(50);
        checkOutput("t4_beats", 64'(hsCount), 64'd6);
        checkOutput("t4_span",  64'(lastHs - firstHs), 64'd5);

        // T5: master backpressure fills the 2-deep FIFO and stalls slave 5
        M_RREADY    = 1'b0;
        acceptCount = 0;
        mkBurst(5, 8, 2'b00, 4'h7, 64'h5000, 1'b1);
        repeat (8) tick();
        checkOutput("t5_accepted", 64'(acceptCount), 64'd2);
        checkOutput("t5_s_rready", 64'(sReadySample), 64'd0);
        checkOutput("t5_m_rvalid", 64'(mValidSample), 64'd1);
        M_RREADY = 1'b1;
        waitDrain(50);

        // Table of request patterns against a freshly reset arbiter
        resetDut();
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i].name, 64'(S_RREADY), 64'(vecs[i].expReady));
            S_RVALID = '0;
        end
        #1;
        checkOutput("vec_no_output", 64'(M_RVALID), 64'd0);

        // T6a: a beat for another master is never accepted
        @(posedge ACLK);
        #1;
        acceptCount = 0;
        mkBurst(4, 1, 2'b01, 4'h3, 64'h6000, 1'b0);
        repeat (4) tick();
        checkOutput("t6_foreign_accept", 64'(acceptCount), 64'd0);
        checkOutput("t6_foreign_ready",  64'(sReadySample), 64'd0);
        checkOutput("t6_foreign_mvalid", 64'(mValidSample), 64'd0);
        slaveQ[4].delete();
        tick();

        // T6b: reset in the middle of a burst drops everything and restores slave 0 priority
        M_RREADY    = 1'b0;
        acceptCount = 0;
        mkBurst(6, 4, 2'b00, 4'h9, 64'h7000, 1'b0);
        repeat (4) tick();
        checkOutput("t6_pre_accept", 64'(acceptCount), 64'd2);
        ARESETn = 1'b0;
        #1;
        checkOutput("t6_rst_s_rready", 64'(S_RREADY), 64'd0);
        checkOutput("t6_rst_m_rvalid", 64'(M_RVALID), 64'd0);
        for (int s = 0; s < SN; s++) slaveQ[s].delete();
        sb.delete();
        S_RVALID = '0;
        hs       = '0;
        @(posedge ACLK);
        #1;
        ARESETn  = 1'b1;
        M_RREADY = 1'b1;
        mkBurst(0, 1, 2'b00, 4'h1, 64'h8000, 1'b1);
        mkBurst(6, 1, 2'b00, 4'h2, 64'h8100, 1'b1);
        tick();
        tick();
        checkOutput("t6_post_grant", 64'(sReadySample), 64'h01);
        waitDrain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
